// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table controller.
package bht_pkg;

    // Tag width carried inside a table entry; bht_controller's TAG_W must match.
    localparam int BHT_TAG_W = 5;

    localparam logic [1:0] CNT_RESET   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T  = 2'b10;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    typedef struct packed {
        logic                 valid;
        logic [BHT_TAG_W-1:0] tag;
        logic [1:0]           counter;
    } bht_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        FLUSH = 2'd3
    } bht_state_t;

    localparam bht_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, counter: CNT_RESET};

    // New entry after a resolved branch: saturating counter on a hit, fresh allocation on a miss.
    function automatic bht_entry_t bht_update(input bht_entry_t old_entry,
                                              input logic [BHT_TAG_W-1:0] tag,
                                              input logic taken);
        bht_entry_t e;
        e = old_entry;
        if (old_entry.valid && (old_entry.tag == tag)) begin
            if (taken) begin
                if (old_entry.counter != 2'b11) e.counter = old_entry.counter + 2'd1;
            end else begin
                if (old_entry.counter != 2'b00) e.counter = old_entry.counter - 2'd1;
            end
        end else begin
            e.valid   = 1'b1;
            e.tag     = tag;
            e.counter = taken ? CNT_WEAK_T : CNT_WEAK_NT;
        end
        return e;
    endfunction

endpackage

// File: rtl/bht_storage.sv
// Branch history table storage: one read port, one write port, per-index valid clear.
// Reads see a same-cycle write to the same index (write-first).
module bht_storage
    import bht_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output bht_entry_t         rd_entry,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  bht_entry_t         wr_entry,
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_index
);

    localparam int DEPTH = 2 ** INDEX_W;

    bht_entry_t entry_array [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            bht_entry_t entry_reg;

            // One entry: full write has precedence over the flush valid-clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= ENTRY_RESET;
                end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
                    entry_reg <= wr_entry;
                end else if (inv_en && (inv_index == INDEX_W'(gi))) begin
                    entry_reg.valid <= 1'b0;
                end
            end

            assign entry_array[gi] = entry_reg;
        end
    endgenerate

    // Read mux with write-first bypass.
    always_comb begin
        rd_entry = entry_array[rd_index];
        if (wr_en && (wr_index == rd_index)) rd_entry = wr_entry;
    end

endmodule

// File: rtl/bht_controller.sv
// Branch history table controller: arbitrates the single read port between fetch
// lookups and execute updates (2-cycle read-modify-write) and runs a table flush.
module bht_controller
    import bht_pkg::*;
#(
    parameter int INDEX_W      = 4,
    parameter int TAG_W        = BHT_TAG_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lk_valid,
    input  logic [INDEX_W-1:0] lk_index,
    output logic               lk_stall,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [1:0]         rd_counter,
    input  logic               upd_req,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic               upd_taken,
    output logic               upd_ack,
    input  logic               flush_req,
    output logic               flush_busy
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    bht_state_t         state_reg;
    logic [STARVE_W-1:0] starve_reg;
    logic               flush_pend_reg;
    logic               flush_busy_reg;
    logic [INDEX_W-1:0] flush_ptr_reg;
    logic               upd_ack_reg;
    logic [INDEX_W-1:0] upd_index_reg;
    logic [TAG_W-1:0]   upd_tag_reg;
    logic               upd_taken_reg;
    bht_entry_t         old_entry_reg;
    bht_entry_t         rd_entry_reg;

    bht_entry_t         port_entry;
    bht_entry_t         new_entry;
    logic [INDEX_W-1:0] port_index;
    logic               starved;
    logic               upd_grant;
    logic               lk_fire;

    // Read-port arbitration: lookups win in IDLE until the update has waited STARVE_LIMIT cycles.
    always_comb begin
        starved    = (starve_reg == STARVE_W'(STARVE_LIMIT));
        upd_grant  = (state_reg == IDLE) && !flush_pend_reg && upd_req && (!lk_valid || starved);
        lk_stall   = lk_valid && ((state_reg == RD) || (state_reg == FLUSH) || upd_grant);
        lk_fire    = lk_valid && !lk_stall;
        port_index = (state_reg == RD) ? upd_index_reg : lk_index;
        new_entry  = bht_update(old_entry_reg, upd_tag_reg, upd_taken_reg);
    end

    bht_storage #(
        .INDEX_W (INDEX_W)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (port_index),
        .rd_entry  (port_entry),
        .wr_en     (state_reg == WR),
        .wr_index  (upd_index_reg),
        .wr_entry  (new_entry),
        .inv_en    (state_reg == FLUSH),
        .inv_index (flush_ptr_reg)
    );

    // Main FSM: update sequencing, starvation counter and flush bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            starve_reg     <= '0;
            flush_pend_reg <= 1'b0;
            flush_busy_reg <= 1'b0;
            flush_ptr_reg  <= '0;
            upd_ack_reg    <= 1'b0;
            upd_index_reg  <= '0;
            upd_tag_reg    <= '0;
            upd_taken_reg  <= 1'b0;
            old_entry_reg  <= ENTRY_RESET;
        end else begin
            upd_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush_pend_reg) begin
                        state_reg      <= FLUSH;
                        flush_pend_reg <= 1'b0;
                        flush_ptr_reg  <= '0;
                    end else begin
                        if (flush_req) begin
                            flush_pend_reg <= 1'b1;
                            flush_busy_reg <= 1'b1;
                        end
                        if (upd_grant) begin
                            state_reg     <= RD;
                            starve_reg    <= '0;
                            upd_index_reg <= upd_index;
                            upd_tag_reg   <= upd_tag;
                            upd_taken_reg <= upd_taken;
                        end else if (upd_req && lk_valid) begin
                            starve_reg <= starve_reg + STARVE_W'(1);
                        end
                    end
                end
                RD: begin
                    old_entry_reg <= port_entry;
                    upd_ack_reg   <= 1'b1;
                    state_reg     <= WR;
                    if (flush_req) begin
                        flush_pend_reg <= 1'b1;
                        flush_busy_reg <= 1'b1;
                    end
                end
                WR: begin
                    state_reg <= IDLE;
                    if (flush_req) begin
                        flush_pend_reg <= 1'b1;
                        flush_busy_reg <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_req) begin
                        flush_ptr_reg <= '0;
                    end else if (flush_ptr_reg == {INDEX_W{1'b1}}) begin
                        state_reg      <= IDLE;
                        flush_busy_reg <= 1'b0;
                    end else begin
                        flush_ptr_reg <= flush_ptr_reg + INDEX_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Lookup result register: only serviced lookups update it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_entry_reg <= ENTRY_RESET;
        end else if (lk_fire) begin
            rd_entry_reg <= port_entry;
        end
    end

    assign rd_valid   = rd_entry_reg.valid;
    assign rd_tag     = rd_entry_reg.tag;
    assign rd_counter = rd_entry_reg.counter;
    assign upd_ack    = upd_ack_reg;
    assign flush_busy = flush_busy_reg;

endmodule

// File: doc/bht_controller.md
Name: bht_controller

Overview:
- Owns the branch history table (valid bit, tag, 2-bit saturating counter per entry) and sequences all access to its single read port.
- Lookups come from fetch. Registered entry fields go to prediction_module as rd_valid, rd_tag and rd_counter.
- Branch resolutions from execute are applied as a 2-cycle read-modify-write.
- Also runs a full-table flush sequence, one entry per cycle.

Parameters:
- INDEX_W, 4, table index width; table has 2**INDEX_W entries.
- TAG_W, 5, tag width; matches the prediction_module tag input.
- STARVE_LIMIT, 3, consecutive cycles an update may be blocked by lookups before it gains priority.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  lookup request this cycle.
- lk_index  in  INDEX_W  lookup index.
- lk_stall  out  1  lookup not serviced this cycle; fetch holds lk_index.
- rd_valid  out  1  registered valid bit of the looked-up entry.
- rd_tag  out  TAG_W  registered tag of the looked-up entry.
- rd_counter  out  2  registered counter of the looked-up entry.
- upd_req  in  1  update request; held until upd_ack.
- upd_index  in  INDEX_W  update index.
- upd_tag  in  TAG_W  resolved branch tag.
- upd_taken  in  1  resolved direction.
- upd_ack  out  1  one-cycle pulse when the update write is committed.
- flush_req  in  1  pulse: invalidate the whole table.
- flush_busy  out  1  high while the flush is pending or running.

Behaviour:
- Reset (async, rst_n=0):
  - all entries: valid=0, tag=0, counter=2'b01.
  - rd_valid=0, rd_tag=0, rd_counter=2'b01.
  - lk_stall=0, upd_ack=0, flush_busy=0.
  - FSM=IDLE, starve counter=0, flush pending cleared.
- Reset mid-operation aborts any RMW or flush; no partial write survives.
- FSM states and transitions:
  - IDLE: if flush pending -> FLUSH. Else if upd_req and the update owns the read port -> RD. Else stay.
  - RD: latch the entry at upd_index -> WR (1 cycle).
  - WR: write the new entry, pulse upd_ack -> IDLE.
  - FLUSH: clear valid of entry flush_ptr, flush_ptr++. On the last index -> IDLE, flush_busy falls the next cycle.
- Read-port arbitration in IDLE:
  - lk_valid wins by default; the update waits and the starve counter increments.
  - When the starve counter equals STARVE_LIMIT, the update wins: lk_stall=1 that cycle and the counter clears.
  - The counter clears whenever RD is entered.
- lk_stall=1 also in every cycle of RD and FLUSH when lk_valid=1. The WR state does not use the read port, so lookups proceed in WR.
- Lookup latency: a serviced lookup in cycle N gives rd_* valid in cycle N+1. Stalled lookups leave rd_* unchanged.
- Update arithmetic, using the entry read in RD:
  - Hit (valid=1, tag==upd_tag): taken -> counter = min(counter+1, 3); not taken -> counter = max(counter-1, 0). No wrap-around.
  - Miss (valid=0 or tag mismatch): allocate valid=1, tag=upd_tag, counter = taken ? 2'b10 : 2'b01.
- Write-first forwarding: a lookup serviced in WR with lk_index==upd_index returns the newly written entry.
- Update inputs are latched on the RD entry. Changes on upd_* during RD/WR are ignored.
- flush_req arriving during RD or WR: set flush pending and flush_busy=1 immediately; the current update completes (upd_ack fires), then FLUSH starts.
- flush_req arriving during FLUSH: restarts flush_ptr at 0.
- Flush has priority over a waiting upd_req in IDLE. The update is serviced after the flush and reads an invalid entry (allocation).
- Flush duration: 2**INDEX_W cycles.

Decomposition:
- Shared package bht_pkg holds:
  - entry typedef {valid, tag[TAG_W], counter[2]}.
  - FSM state enum {IDLE, RD, WR, FLUSH}.
  - constants CNT_RESET=2'b01, CNT_WEAK_T=2'b10, CNT_WEAK_NT=2'b01.
- One sub-module, bht_storage: register array with one read port, one write port, a bulk-invalidate-by-index port, write-first bypass, and async reset of all entries.
- Arbitration, FSM, counter update and output registers stay in bht_controller.

Test Plan:
- Reset, then lookup index 3 -> next cycle rd_valid=0, rd_counter=01, lk_stall=0.
- Miss allocation: upd_req index 5, tag 0x12, taken=1, no lookups -> upd_ack 2 cycles later; a later lookup of 5 gives rd_valid=1, rd_tag=0x12, rd_counter=10.
- Saturation: three taken updates on index 5/tag 0x12 -> counter 11 then stays 11; four not-taken updates -> 10, 01, 00, 00.
- Starvation: lk_valid held high with upd_req pending -> update stalled 3 cycles; 4th cycle lk_stall=1 and RD entered; upd_ack 2 cycles later.
- Forwarding: lookup index 5 in the WR cycle of an update to index 5 -> rd_* next cycle equals the newly written entry.
- Flush during RD with INDEX_W=4: the pending upd_ack still fires; flush_busy stays high through 16 FLUSH cycles; lookups stalled; afterwards every index reads rd_valid=0.
- Async reset mid-FLUSH (rst_n low for 1 ns) -> all outputs at reset values immediately; FSM=IDLE.
